// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file read-port sequencer.
//   state_e : sequencer FSM states
//     IDLE - waiting for a request
//     RD1  - reading operand 1
//     RD2  - reading operand 2
//     WAIT - last read data returns
//     OUT  - presenting operands
package rf_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WAIT = 3'd3,
    OUT  = 3'd4
  } state_e;

endpackage

// File: rtl/rf_operand_slot.sv
// One operand of a read request. It holds the latched address and enable,
// tracks an outstanding macro read, and keeps the operand value coherent
// with writeback traffic.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   load                request accepted: latch load_addr / load_en and clear
//                       the value
//   load_addr, load_en  operand address and enable from the request
//   issue               a macro read for this operand is issued this cycle
//   rd_data             macro read data, valid the cycle after issue
//   wr_v                writeback valid (already filtered for the zero register)
//   wr_addr, wr_data    writeback address and data
//   addr, en            latched address and enable
//   zero                latched address is the hardwired-zero register
//   data                operand value
module rf_operand_slot #(
  parameter int width_p      = 32,
  parameter int addr_width_p = 5,
  parameter int zero_reg_p   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [addr_width_p-1:0] load_addr,
  input  logic                    load_en,
  input  logic                    issue,
  input  logic [width_p-1:0]      rd_data,
  input  logic                    wr_v,
  input  logic [addr_width_p-1:0] wr_addr,
  input  logic [width_p-1:0]      wr_data,
  output logic [addr_width_p-1:0] addr,
  output logic                    en,
  output logic                    zero,
  output logic [width_p-1:0]      data
);

  logic [addr_width_p-1:0] addr_r;
  logic                    en_r;
  logic                    pend_r;  // read issued last cycle; data arrives now
  logic                    fwd_r;   // write hit in the issue cycle; data_r wins
  logic                    held_r;  // value captured; later writes overwrite
  logic [width_p-1:0]      data_r;
  logic                    match;

  assign match = wr_v & en_r & (wr_addr == addr_r);

  // NOTE: every register below is assigned with <= so that all of them update
  // from the same pre-edge values; a blocking = here would let later
  // statements see this cycle's new values and break the capture ordering.
  // NOTE: data_r is reset as well as re-cleared on load, because the operand
  // outputs must read 0 out of reset and a new request must never show stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r <= '0;
      en_r   <= 1'b0;
      pend_r <= 1'b0;
      fwd_r  <= 1'b0;
      held_r <= 1'b0;
      data_r <= '0;
    end else if (load) begin
      addr_r <= load_addr;
      en_r   <= load_en;
      pend_r <= 1'b0;
      fwd_r  <= 1'b0;
      held_r <= 1'b0;
      data_r <= '0;
    end else if (issue) begin
      // The macro returns the pre-write value for a write in the read cycle,
      // so remember the write and let it override the returned data.
      pend_r <= 1'b1;
      fwd_r  <= match;
      if (match) data_r <= wr_data;
    end else if (pend_r) begin
      // A write in the capture cycle is newer than both the macro data and
      // any forwarded value.
      pend_r <= 1'b0;
      fwd_r  <= 1'b0;
      held_r <= 1'b1;
      if (match)      data_r <= wr_data;
      else if (!fwd_r) data_r <= rd_data;
    end else if (held_r && match) begin
      data_r <= wr_data;
    end
  end

  assign addr = addr_r;
  assign en   = en_r;
  assign zero = (zero_reg_p != 0) && (addr_r == '0);
  assign data = data_r;

endmodule

// File: rtl/rf_read_port_sequencer.sv
// Serialises a two-operand read request onto the single synchronous read port
// of a 1R/1W register-file macro, forwards writebacks into in-flight and held
// operands, and passes the write port through with a hardwired-zero register.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   v_i / ready_o             request handshake
//   rs1_en_i, rs1_addr_i      operand 1 request
//   rs2_en_i, rs2_addr_i      operand 2 request
//   v_o / yumi_i              operand handshake
//   rs1_data_o, rs2_data_o    operand values (0 when disabled or zero register)
//   w_v_i, w_addr_i, w_data_i writeback from the pipeline
//   rf_r_v_o, rf_r_addr_o     macro read port; rf_r_data_i returns a cycle later
//   rf_w_v_o, rf_w_addr_o,
//   rf_w_data_o               macro write port
module rf_read_port_sequencer
  import rf_seq_pkg::*;
#(
  parameter int  els_p         = 32,
  parameter int  width_p       = 32,
  parameter int  zero_reg_p    = 1,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     rs1_en_i,
  input  logic [addr_width_lp-1:0] rs1_addr_i,
  input  logic                     rs2_en_i,
  input  logic [addr_width_lp-1:0] rs2_addr_i,
  output logic                     v_o,
  output logic [width_p-1:0]       rs1_data_o,
  output logic [width_p-1:0]       rs2_data_o,
  input  logic                     yumi_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  output logic                     rf_r_v_o,
  output logic [addr_width_lp-1:0] rf_r_addr_o,
  input  logic [width_p-1:0]       rf_r_data_i,
  output logic                     rf_w_v_o,
  output logic [addr_width_lp-1:0] rf_w_addr_o,
  output logic [width_p-1:0]       rf_w_data_o
);

  state_e                   state_r, state_n;
  logic                     accept;
  logic                     issue1, issue2;
  logic [addr_width_lp-1:0] s1_addr, s2_addr;
  logic                     s1_en, s2_en, s1_zero, s2_zero;

  // Write passthrough; writes to the zero register never reach the macro and
  // therefore never forward into an operand either.
  assign rf_w_v_o    = w_v_i & ~reset_i
                     & ~((zero_reg_p != 0) && (w_addr_i == '0));
  assign rf_w_addr_o = w_addr_i;
  assign rf_w_data_o = w_data_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n     = state_r;
    ready_o     = 1'b0;
    v_o         = 1'b0;
    rf_r_v_o    = 1'b0;
    rf_r_addr_o = s1_addr;
    case (state_r)
      IDLE: begin
        ready_o = ~reset_i;
        if (v_i) begin
          if (rs1_en_i)      state_n = RD1;
          else if (rs2_en_i) state_n = RD2;
          else               state_n = OUT;
        end
      end
      RD1: begin
        rf_r_v_o    = s1_en & ~s1_zero;
        rf_r_addr_o = s1_addr;
        state_n     = s2_en ? RD2 : WAIT;
      end
      RD2: begin
        rf_r_v_o    = s2_en & ~s2_zero;
        rf_r_addr_o = s2_addr;
        state_n     = WAIT;
      end
      WAIT: state_n = OUT;
      OUT: begin
        v_o = 1'b1;
        if (yumi_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign accept = ready_o & v_i;
  assign issue1 = (state_r == RD1) & rf_r_v_o;
  assign issue2 = (state_r == RD2) & rf_r_v_o;

  rf_operand_slot #(
    .width_p(width_p), .addr_width_p(addr_width_lp), .zero_reg_p(zero_reg_p)
  ) slot1 (
    .clk(clk_i), .reset(reset_i), .load(accept),
    .load_addr(rs1_addr_i), .load_en(rs1_en_i), .issue(issue1),
    .rd_data(rf_r_data_i), .wr_v(rf_w_v_o), .wr_addr(w_addr_i),
    .wr_data(w_data_i), .addr(s1_addr), .en(s1_en), .zero(s1_zero),
    .data(rs1_data_o)
  );

  rf_operand_slot #(
    .width_p(width_p), .addr_width_p(addr_width_lp), .zero_reg_p(zero_reg_p)
  ) slot2 (
    .clk(clk_i), .reset(reset_i), .load(accept),
    .load_addr(rs2_addr_i), .load_en(rs2_en_i), .issue(issue2),
    .rd_data(rf_r_data_i), .wr_v(rf_w_v_o), .wr_addr(w_addr_i),
    .wr_data(w_data_i), .addr(s2_addr), .en(s2_en), .zero(s2_zero),
    .data(rs2_data_o)
  );

  // Consumers may only take operands that are being presented.
  assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
    else $error("yumi_i asserted while v_o is low");

endmodule
